// File: rtl/hilo_muldiv_seq.sv
// hilo_muldiv_seq: iterative MULT/MULTU/DIV/DIVU engine that owns HI/LO.
// One radix-2 step per cycle (WIDTH steps), then a sign-fix cycle.
// Ports:
//   clk, reset      rising-edge clock, async active-high reset
//   start, op, a, b issue mul/div (op: 00 MULT 01 MULTU 10 DIV 11 DIVU)
//   hi_we, lo_we    MTHI/MTLO strobes with wdata
//   hi, lo          HI/LO registers
//   busy, stall     in flight / hold PC and regfile write
//   done            one-cycle pulse once hi/lo hold the new result
module hilo_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE, CALC, FIX, DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mb, r, q;
  logic             sa, sb, is_div;

  logic             open_st, accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH:0]   msum, madd;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  logic [2*WIDTH-1:0] prod, prod_n;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign open_st = (state == IDLE) || (state == DONE);
  assign accept  = start & open_st;

  assign busy  = (state == CALC) || (state == FIX);
  assign stall = accept | busy;
  assign done  = (state == DONE);

  // Signed ops work on magnitudes; sign is restored in FIX.
  assign a_neg = ~op[0] & a[WIDTH-1];
  assign b_neg = ~op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;

  // Multiply: {r,q} shifts right, adding mb when the low bit is set.
  assign msum = {1'b0, r} + {1'b0, mb};
  assign madd = q[0] ? msum : {1'b0, r};

  // Divide: restoring step; r < mb keeps the difference within WIDTH.
  assign shifted = {r, q[WIDTH-1]};
  assign fits    = shifted >= {1'b0, mb};
  assign diff    = shifted[WIDTH-1:0] - mb;

  assign prod   = {r, q};
  assign prod_n = ~prod + 1'b1;

  always_comb begin
    res_hi = r;
    res_lo = q;
    if (!is_div) begin
      {res_hi, res_lo} = (sa ^ sb) ? prod_n : prod;
    end else begin
      res_hi = sa ? (~r + 1'b1) : r;
      // Divide by zero leaves r = |a|, so hi = a; lo is forced to ones.
      if (mb == '0)
        res_lo = '1;
      else if (sa ^ sb)
        res_lo = ~q + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = CALC;
      CALC: if (count == CW'(WIDTH-1)) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: state_nx = start ? CALC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      mb     <= '0;
      r      <= '0;
      q      <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      is_div <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        sa     <= a_neg;
        sb     <= b_neg;
        is_div <= op[1];
        mb     <= b_mag;
        r      <= '0;
        q      <= a_mag;
        count  <= '0;
      end else if (open_st) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end else if (state == CALC) begin
        count <= count + 1'b1;
        if (is_div) begin
          r <= fits ? diff : shifted[WIDTH-1:0];
          q <= {q[WIDTH-2:0], fits};
        end else begin
          r <= madd[WIDTH:1];
          q <= {madd[0], q[WIDTH-1:1]};
        end
      end else if (state == FIX) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule
